// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional misaligned-PC fault detection is compiled in when IF_MISALIGN_CHECK_EN is defined.
module if_fetch_stage #(
   parameter int unsigned     WORD      = 32,
   parameter logic [WORD-1:0] PC_RESET  = 32'h0000_0000,
   parameter int unsigned     MEM_BYTES = 168,
   parameter logic [WORD-1:0] NOP_WORD  = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic [WORD-1:0] pc_out,
   input  logic [WORD-1:0] instr_in,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [WORD-1:0] branch_target,
   input  logic            jump,
   input  logic [WORD-1:0] jump_target,
   output logic [WORD-1:0] ifid_instr,
   output logic [WORD-1:0] ifid_pc4,
   output logic            ifid_valid,
   output logic            done
`ifdef IF_MISALIGN_CHECK_EN
   ,
   output logic            fetch_fault
`endif
);

   localparam logic [WORD-1:0] MEM_LIMIT = WORD'(MEM_BYTES);

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_END   = 1'b1
   } state_t;

   // What the stage does this cycle, resolved once so state and datapath agree.
   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_REDIRECT,
      ACT_PARK,
      ACT_FAULT,
      ACT_CAPTURE
   } action_t;

   state_t          state_q, state_d;
   logic [WORD-1:0] pc_q, pc_d;
   logic [WORD-1:0] instr_q, instr_d;
   logic [WORD-1:0] pc4_q, pc4_d;
   logic            valid_q, valid_d;
   logic            fault_q, fault_d;

   action_t         action;
   logic            redirect;
   logic [WORD-1:0] redirect_target;
   logic [WORD-1:0] pc_plus4;
   logic            pc_in_range;
   logic            pc_misaligned;

   assign redirect        = branch_taken | jump;
   assign redirect_target = jump ? jump_target : branch_target;
   assign pc_plus4        = pc_q + WORD'(4);
   assign pc_in_range     = (pc_q < MEM_LIMIT);

`ifdef IF_MISALIGN_CHECK_EN
   assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
   assign pc_misaligned = 1'b0;
`endif

   always_comb begin
      action = ACT_HOLD;
      if (stall) begin
         action = ACT_HOLD;
      end else if (redirect) begin
         action = ACT_REDIRECT;
      end else if (state_q == ST_END) begin
         action = ACT_PARK;
      end else if (pc_misaligned) begin
         action = ACT_FAULT;
      end else if (!pc_in_range) begin
         action = ACT_PARK;
      end else begin
         action = ACT_CAPTURE;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (action)
         ACT_REDIRECT: state_d = ST_FETCH;
         ACT_PARK,
         ACT_FAULT:    state_d = ST_END;
         ACT_CAPTURE:  state_d = (pc_plus4 >= MEM_LIMIT) ? ST_END : ST_FETCH;
         default:      state_d = state_q;
      endcase
   end

   // Output logic: done is a pure function of the state.
   always_comb begin
      pc_out     = pc_q;
      ifid_instr = instr_q;
      ifid_pc4   = pc4_q;
      ifid_valid = valid_q;
      done       = (state_q == ST_END);
   end

`ifdef IF_MISALIGN_CHECK_EN
   assign fetch_fault = fault_q;
`endif

   // Datapath next values for PC, IF/ID and the sticky fault flag.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      fault_d = fault_q;
      unique case (action)
         ACT_REDIRECT: begin
            pc_d    = redirect_target;
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
         end
         ACT_PARK: begin
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
         end
         ACT_FAULT: begin
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
            fault_d = 1'b1;
         end
         ACT_CAPTURE: begin
            pc_d    = pc_plus4;
            instr_d = instr_in;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
         end
         default: begin
            pc_d = pc_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= PC_RESET;
         instr_q <= NOP_WORD;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

`ifndef IF_MISALIGN_CHECK_EN
   // Fault flag stays at its reset value when the check is compiled out.
   logic unused_fault;
   assign unused_fault = fault_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized self-checking bench for if_fetch_stage against a cycle-level behavioural model.
// Define IF_MISALIGN_CHECK_EN to also exercise the misaligned-fetch fault output.
module tb_if_fetch_stage;

   localparam int MEM_LINES = 42;
   localparam logic [31:0] MEM_END = 32'd168;

   logic        clk;
   logic        reset;
   logic [31:0] pc_out;
   logic [31:0] instr_in;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        done;
`ifdef IF_MISALIGN_CHECK_EN
   logic        fetch_fault;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:MEM_LINES-1];

   // Behavioural model state
   logic [31:0] m_pc, m_instr, m_pc4;
   bit          m_valid, m_end, m_fault;

   if_fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .pc_out       (pc_out),
      .instr_in     (instr_in),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .ifid_instr   (ifid_instr),
      .ifid_pc4     (ifid_pc4),
      .ifid_valid   (ifid_valid),
      .done         (done)
`ifdef IF_MISALIGN_CHECK_EN
      ,
      .fetch_fault  (fetch_fault)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < MEM_END) return mem[int'(a >> 2)];
      return 32'hBAD0_0000 ^ a;
   endfunction

   assign instr_in = mem_word(pc_out);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit rst, input bit st, input bit bt, input bit j,
                             input logic [31:0] btgt, input logic [31:0] jtgt);
      if (rst) begin
         m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_end = 0; m_fault = 0;
      end else if (st) begin
         // everything holds
      end else if (bt || j) begin
         m_pc = j ? jtgt : btgt;
         m_instr = 0; m_pc4 = 0; m_valid = 0; m_end = 0;
      end else if (m_end) begin
         m_instr = 0; m_pc4 = 0; m_valid = 0;
`ifdef IF_MISALIGN_CHECK_EN
      end else if (m_pc % 4 != 0) begin
         m_instr = 0; m_pc4 = 0; m_valid = 0; m_end = 1; m_fault = 1;
`endif
      end else if (m_pc >= MEM_END) begin
         m_instr = 0; m_pc4 = 0; m_valid = 0; m_end = 1;
      end else begin
         m_instr = mem_word(m_pc);
         m_pc4   = m_pc + 4;
         m_valid = 1;
         m_pc    = m_pc + 4;
         if (m_pc >= MEM_END) m_end = 1;
      end
   endtask

   task automatic compare_all();
      check("pc_out", pc_out, m_pc);
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_pc4", ifid_pc4, m_pc4);
      check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
      check("done", {31'b0, done}, {31'b0, m_end});
`ifdef IF_MISALIGN_CHECK_EN
      check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
`endif
   endtask

   // One clock: drive inputs, advance model at the edge, compare on the falling edge.
   task automatic step(input bit rst, input bit st, input bit bt, input bit j,
                       input logic [31:0] btgt, input logic [31:0] jtgt);
      reset = rst; stall = st; branch_taken = bt; jump = j;
      branch_target = btgt; jump_target = jtgt;
      @(posedge clk);
      model_step(rst, st, bt, j, btgt, jtgt);
      @(negedge clk);
      compare_all();
      $display("[TB] rst=%0d st=%0d br=%0d j=%0d -> pc=%h ifid={%h,%h,%0d} done=%0d",
               rst, st, bt, j, pc_out, ifid_instr, ifid_pc4, ifid_valid, done);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 5))
         0, 1, 2: return 32'($urandom_range(0, MEM_LINES - 1)) * 4;
         3:       return 32'hA0 + 32'($urandom_range(0, 2)) * 4;
         4:       return 32'hC0;
         default: return 32'($urandom_range(0, MEM_LINES - 1)) * 4 + 32'($urandom_range(1, 3));
      endcase
   endfunction

   initial begin
      reset = 1; stall = 0; branch_taken = 0; jump = 0;
      branch_target = 0; jump_target = 0;
      for (int i = 0; i < MEM_LINES; i++) mem[i] = $urandom;
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h2009_0003;
      mem[2] = 32'h0109_5020;
      @(negedge clk);

      // Reset and free run
      step(1, 0, 0, 0, 0, 0);
      check("rst_pc", pc_out, 32'h0);
      check("rst_valid", {31'b0, ifid_valid}, 32'h0);
      step(0, 0, 0, 0, 0, 0);
      check("run1_instr", ifid_instr, 32'h2008_0005);
      check("run1_pc4", ifid_pc4, 32'h4);
      step(0, 0, 0, 0, 0, 0);
      check("run2_pc", pc_out, 32'h8);

      // Stall at PC=8, ignoring a concurrent jump on the second stalled cycle
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 32'h40);
      check("stall_pc", pc_out, 32'h8);
      check("stall_instr", ifid_instr, 32'h2009_0003);
      step(0, 0, 0, 0, 0, 0);
      check("release_pc", pc_out, 32'hC);
      run(1);

      // Taken branch at 0x10
      step(0, 0, 1, 0, 32'h20, 0);
      check("br_pc", pc_out, 32'h20);
      check("br_bubble", {31'b0, ifid_valid}, 32'h0);
      step(0, 0, 0, 0, 0, 0);
      check("br_fetch_pc4", ifid_pc4, 32'h24);

      // Jump beats branch
      step(0, 0, 1, 1, 32'h60, 32'h40);
      check("jmp_prio_pc", pc_out, 32'h40);

      // Run to end of program
      step(0, 0, 0, 1, 0, 32'h9C);
      run(3);
      check("end_pc4", ifid_pc4, 32'hA8);
      check("end_done", {31'b0, done}, 32'h1);
      run(3);
      check("end_bubble", {31'b0, ifid_valid}, 32'h0);
      step(0, 0, 0, 1, 0, 32'h0);
      check("leave_end_done", {31'b0, done}, 32'h0);
      run(2);

      // Redirect out of range parks on the next cycle
      step(0, 0, 1, 0, 32'hC0, 0);
      run(2);

      // Reset mid-stall and mid-END
      step(0, 0, 0, 1, 0, 32'h8);
      step(1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 32'hA4);
      run(3);
      step(1, 0, 1, 1, 32'h20, 32'h30);
      check("rst_end_pc", pc_out, 32'h0);

`ifdef IF_MISALIGN_CHECK_EN
      step(0, 0, 0, 1, 0, 32'h22);
      step(0, 0, 0, 0, 0, 0);
      check("mis_fault", {31'b0, fetch_fault}, 32'h1);
      check("mis_done", {31'b0, done}, 32'h1);
      step(0, 0, 0, 1, 0, 32'h0);
      run(1);
      check("mis_sticky", {31'b0, fetch_fault}, 32'h1);
      step(1, 0, 0, 0, 0, 0);
`endif

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         bit r, s, b, j;
         r = ($urandom_range(0, 99) < 1);
         s = ($urandom_range(0, 99) < 25);
         b = ($urandom_range(0, 99) < 10);
         j = ($urandom_range(0, 99) < 8);
         step(r, s, b, j, pick_target(), pick_target());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and next-PC selection. Drives the byte address into the combinational instruction memory and captures the returned word into the IF/ID pipeline register.
- Accepts stall from the hazard unit and branch/jump redirects resolved in ID.
- Detects end of program and parks in a done state.

Parameters:
- WORD, 32, datapath and address width.
- PC_RESET, 32'h0000_0000, PC value after reset.
- MEM_BYTES, 168, instruction memory size in bytes (42 lines x 4); first out-of-program address.
- NOP_WORD, 32'h0000_0000, word injected into IF/ID on flush, end, or fault.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pc_out  output  WORD  current PC; wired to instruction memory read_addr.
- instr_in  input  WORD  instruction returned combinationally for pc_out.
- stall  input  1  hazard unit: hold PC and IF/ID.
- branch_taken  input  1  ID resolved a taken branch.
- branch_target  input  WORD  branch destination.
- jump  input  1  ID decoded j/jal.
- jump_target  input  WORD  jump destination.
- ifid_instr  output  WORD  IF/ID instruction.
- ifid_pc4  output  WORD  IF/ID PC+4.
- ifid_valid  output  1  IF/ID holds a real instruction.
- done  output  1  fetch reached end of program.

Behaviour:
- On reset (sampled at posedge clk):
  - PC=PC_RESET, ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0, done=0.
  - state=FETCH.
  - Reset overrides every other input, including mid-stall or mid-redirect.
- pc_out is the PC register directly; no combinational path from inputs to pc_out.
- PC+4 is computed modulo 2^WORD.
- redirect = branch_taken | jump. When both are asserted, jump wins.
- Per-cycle priority (after reset): stall > redirect > sequential.
- stall=1:
  - PC, IF/ID and state all hold.
  - A redirect asserted in the same cycle is ignored; ID re-presents it after the stall.
- redirect=1, stall=0:
  - PC <= target.
  - IF/ID <= {NOP_WORD, 0, valid=0} (flushes the wrong-path word).
  - state <= FETCH, done <= 0.
- Otherwise in FETCH:
  - IF/ID <= {instr_in, PC+4, valid=1}.
  - PC <= PC+4.
  - If PC+4 >= MEM_BYTES: state <= END, done <= 1.
- END state:
  - PC holds at its last value.
  - IF/ID <= {NOP_WORD, 0, valid=0} every unstalled cycle.
  - instr_in is ignored.
  - Only a redirect (branch/jump still draining from ID) or reset leaves END.
- Whenever PC >= MEM_BYTES in FETCH (e.g. redirect out of range):
  - Treat as END on that cycle: no capture, state <= END.
- Fetch-to-IF/ID latency: one cycle. Taken redirect penalty: one bubble.

Optional Feature:
- Macro IF_MISALIGN_CHECK_EN.
- When defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - If PC[1:0] != 0 in FETCH with stall=0 and no redirect:
    - IF/ID <= NOP bubble, valid=0.
    - fetch_fault <= 1, sticky until reset.
    - state <= END, done <= 1.
- When undefined:
  - No fetch_fault port.
  - PC[1:0] is ignored, and the misaligned word is captured as returned.

Test Plan:
- Reset then 3 free-run cycles, memory returning 0x20080005/0x20090003/0x01095020:
  - pc_out goes 0,4,8,C.
  - ifid_instr follows one cycle behind; ifid_pc4 = 4,8,C; ifid_valid=1 from cycle 1.
- stall held 2 cycles at PC=8:
  - pc_out stays 8; IF/ID keeps {instr@4, 8, 1}.
  - Release → PC=C next edge.
- branch_taken=1, target=0x20 at PC=0x10:
  - Next cycle PC=0x20, ifid_valid=0, ifid_instr=0.
  - Following cycle IF/ID={instr@0x20, 0x24, 1}.
- stall=1 with jump=1 (target 0x40) at PC=0x14: PC stays 0x14.
- stall=0 with jump=1 and branch_taken=1 (targets 0x40/0x60): PC=0x40.
- Sequential run to PC=0xA4 (MEM_BYTES=168):
  - Edge captures instr@0xA4, PC=0xA8, done=1.
  - Subsequent IF/ID are bubbles.
  - A later jump to 0x0 clears done and fetches from 0.
- Reset asserted mid-stall and mid-END: all outputs return to reset values next edge.
- With IF_MISALIGN_CHECK_EN defined, jump to 0x22: next cycle fetch_fault=1, done=1, ifid_valid=0.
